// File: rtl/cpu_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared constants and types for the CPU memory port-A arbiter.
//   ADDR_W      : address width (4 KiB space)
//   DATA_W      : data width
//   PROT_LIMIT  : writes below this address are suppressed
//   owner_t     : who owns an access / response (NONE, LDR, CPU, DRW)
//   state_t     : arbiter FSM states (ARB, LOCKED)
// ----------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int PROT_LIMIT = 'h200;

    typedef enum logic [1:0] {
        NONE,
        LDR,
        CPU,
        DRW
    } owner_t;

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    // True for a write that lands in the protected low region.
    function automatic logic is_protected(input logic write, input logic [ADDR_W-1:0] addr);
        return write && (addr < ADDR_W'(PROT_LIMIT));
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// cpu_mem_arbiter_if
// Bundles the three requester handshakes and the memory port-A pins.
//   slave  : the arbiter side (takes requests and mem_rdata, drives grants,
//            read valids, shared rdata and the mem_* pins)
//   master : the system side (requesters and the memory itself)
// ----------------------------------------------------------------------------
interface cpu_mem_arbiter_if;
    import cpu_mem_pkg::*;

    logic              ldr_req;
    logic              ldr_lock;
    logic              ldr_write;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;

    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;

    logic              drw_req;
    logic [ADDR_W-1:0] drw_addr;
    logic              drw_gnt;
    logic              drw_rvalid;

    logic [DATA_W-1:0] rdata;

    logic              mem_en;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ldr_req, ldr_lock, ldr_write, ldr_addr, ldr_wdata,
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
        input  drw_req, drw_addr,
        input  mem_rdata,
        output ldr_gnt, ldr_rvalid, cpu_gnt, cpu_rvalid, drw_gnt, drw_rvalid,
        output rdata,
        output mem_en, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output ldr_req, ldr_lock, ldr_write, ldr_addr, ldr_wdata,
        output cpu_req, cpu_write, cpu_addr, cpu_wdata,
        output drw_req, drw_addr,
        output mem_rdata,
        input  ldr_gnt, ldr_rvalid, cpu_gnt, cpu_rvalid, drw_gnt, drw_rvalid,
        input  rdata,
        input  mem_en, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cpu_mem_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker between the CPU and the draw unit.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : arbitration allowed this cycle (no loader grant / lock)
//   cpu_req      : CPU request        -> cpu_gnt
//   drw_req      : draw unit request  -> drw_gnt
// On a tie the side that did not win last time is granted. The last winner
// resets to DRW so the CPU takes the first tie.
// ----------------------------------------------------------------------------
module rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic cpu_req,
    input  logic drw_req,
    output logic cpu_gnt,
    output logic drw_gnt
);

    owner_t rr_last;

    assign cpu_gnt = en && cpu_req && (!drw_req || (rr_last == DRW));
    assign drw_gnt = en && drw_req && (!cpu_req || (rr_last != DRW));

    // Remember the last winner; only actual grants move the pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= DRW;
        end else if (cpu_gnt) begin
            rr_last <= CPU;
        end else if (drw_gnt) begin
            rr_last <= DRW;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_mem_arbiter
// Shares memory port A among the ROM loader, the CPU and the draw unit.
// One access per clock; read data returns one cycle later to its owner.
// Writes below PROT_LIMIT are granted but never reach the memory.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : cpu_mem_arbiter_if.slave (requesters + memory pins)
// Optional build macro ARB_WPROT_ERR_EN adds:
//   wp_err  (out) : sticky flag, a protected write was dropped
//   wp_addr (out) : address of the first dropped write
//   wp_clr  (in)  : clears wp_err/wp_addr (a same-cycle violation wins)
// ----------------------------------------------------------------------------
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    cpu_mem_arbiter_if.slave  bus
`ifdef ARB_WPROT_ERR_EN
    ,
    output logic              wp_err,
    output logic [ADDR_W-1:0] wp_addr,
    input  logic              wp_clr
`endif
);

    state_t            state, state_next;
    owner_t            resp_owner, resp_owner_next;
    logic              rr_en;
    logic              ldr_gnt, cpu_gnt, drw_gnt;
    logic              any_gnt;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              prot_hit;

    // The loader always wins. Nothing is issued while reset is asserted.
    assign ldr_gnt = reset_n && bus.ldr_req;

    // FSM next state and the CPU/draw enable. LOCKED blocks the CPU and draw
    // unit only while ldr_lock is still high, so the cycle the lock drops
    // already arbitrates normally.
    always_comb begin
        state_next = state;
        rr_en      = 1'b0;
        case (state)
            ARB: begin
                rr_en = reset_n && !bus.ldr_req;
                if (ldr_gnt && bus.ldr_lock) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                rr_en = reset_n && !bus.ldr_req && !bus.ldr_lock;
                if (!bus.ldr_lock) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (rr_en),
        .cpu_req (bus.cpu_req),
        .drw_req (bus.drw_req),
        .cpu_gnt (cpu_gnt),
        .drw_gnt (drw_gnt)
    );

    // Route the winning request onto the memory pins and note who is owed
    // read data next cycle. The draw unit only ever reads.
    always_comb begin
        any_gnt         = 1'b0;
        sel_write       = 1'b0;
        sel_addr        = '0;
        sel_wdata       = '0;
        resp_owner_next = NONE;
        if (ldr_gnt) begin
            any_gnt   = 1'b1;
            sel_write = bus.ldr_write;
            sel_addr  = bus.ldr_addr;
            sel_wdata = bus.ldr_wdata;
            if (!bus.ldr_write) resp_owner_next = LDR;
        end else if (cpu_gnt) begin
            any_gnt   = 1'b1;
            sel_write = bus.cpu_write;
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
            if (!bus.cpu_write) resp_owner_next = CPU;
        end else if (drw_gnt) begin
            any_gnt         = 1'b1;
            sel_addr        = bus.drw_addr;
            resp_owner_next = DRW;
        end
        prot_hit = any_gnt && is_protected(sel_write, sel_addr);
    end

    // State and response-owner registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB;
            resp_owner <= NONE;
        end else begin
            state      <= state_next;
            resp_owner <= resp_owner_next;
        end
    end

    assign bus.ldr_gnt    = ldr_gnt;
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.drw_gnt    = drw_gnt;
    assign bus.mem_en     = any_gnt && !prot_hit;
    assign bus.mem_write  = any_gnt && sel_write && !prot_hit;
    assign bus.mem_addr   = sel_addr;
    assign bus.mem_wdata  = sel_wdata;
    assign bus.ldr_rvalid = (resp_owner == LDR);
    assign bus.cpu_rvalid = (resp_owner == CPU);
    assign bus.drw_rvalid = (resp_owner == DRW);
    assign bus.rdata      = (resp_owner != NONE) ? bus.mem_rdata : '0;

`ifdef ARB_WPROT_ERR_EN
    // Sticky capture of the first dropped write. A new violation in the same
    // cycle as wp_clr re-arms the flag with the new address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_err  <= 1'b0;
            wp_addr <= '0;
        end else if (prot_hit && (!wp_err || wp_clr)) begin
            wp_err  <= 1'b1;
            wp_addr <= sel_addr;
        end else if (wp_clr) begin
            wp_err  <= 1'b0;
            wp_addr <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpu_mem_arbiter
// Directed bench for cpu_mem_arbiter with a behavioural port-A memory
// (registered read, 1-cycle latency). Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
// ----------------------------------------------------------------------------
module tb_cpu_mem_arbiter;
    import cpu_mem_pkg::*;

    logic clk;
    logic reset_n;
    int   check_count;
    int   fail_count;
    logic [DATA_W-1:0] ram [0:4095];
    logic [DATA_W-1:0] saved_1ff;
    logic [DATA_W-1:0] saved_100;
    logic exp_cpu;
    logic prev_cpu;

    cpu_mem_arbiter_if bus ();

`ifdef ARB_WPROT_ERR_EN
    logic              wp_err;
    logic [ADDR_W-1:0] wp_addr;
    logic              wp_clr;
`endif

    cpu_mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef ARB_WPROT_ERR_EN
        ,
        .wp_err  (wp_err),
        .wp_addr (wp_addr),
        .wp_clr  (wp_clr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Port-A memory model: write or registered read when enabled.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
            else               bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of requests after the falling edge, then settle.
    task automatic applyStimulus(
        input logic l_req, input logic l_lock, input logic l_write,
        input logic [ADDR_W-1:0] l_addr, input logic [DATA_W-1:0] l_wdata,
        input logic c_req, input logic c_write,
        input logic [ADDR_W-1:0] c_addr, input logic [DATA_W-1:0] c_wdata,
        input logic d_req, input logic [ADDR_W-1:0] d_addr);
        @(negedge clk);
        bus.ldr_req   = l_req;
        bus.ldr_lock  = l_lock;
        bus.ldr_write = l_write;
        bus.ldr_addr  = l_addr;
        bus.ldr_wdata = l_wdata;
        bus.cpu_req   = c_req;
        bus.cpu_write = c_write;
        bus.cpu_addr  = c_addr;
        bus.cpu_wdata = c_wdata;
        bus.drw_req   = d_req;
        bus.drw_addr  = d_addr;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 12'h000);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        reset_n     = 1'b0;
        bus.ldr_req = 0; bus.ldr_lock = 0; bus.ldr_write = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        bus.cpu_req = 0; bus.cpu_write = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.drw_req = 0; bus.drw_addr = '0;
`ifdef ARB_WPROT_ERR_EN
        wp_clr = 1'b0;
`endif
        #2;
        checkOutput("rst_gnts",   32'({bus.ldr_gnt, bus.cpu_gnt, bus.drw_gnt}), 0);
        checkOutput("rst_mem",    32'({bus.mem_en, bus.mem_write}), 0);
        checkOutput("rst_addr",   32'(bus.mem_addr), 0);
        checkOutput("rst_rvalid", 32'({bus.ldr_rvalid, bus.cpu_rvalid, bus.drw_rvalid}), 0);
`ifdef ARB_WPROT_ERR_EN
        checkOutput("rst_wp", 32'({wp_err, wp_addr}), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Preload 0x200=AB and 0x201=CD through the loader.
        applyStimulus(1, 0, 1, 12'h200, 8'hAB, 0, 0, 12'h000, 8'h00, 0, 12'h000);
        checkOutput("pre_ldr_gnt", 32'(bus.ldr_gnt), 1);
        checkOutput("pre_mem_wr",  32'({bus.mem_en, bus.mem_write}), 3);
        applyStimulus(1, 0, 1, 12'h201, 8'hCD, 0, 0, 12'h000, 8'h00, 0, 12'h000);
        idleCycle();
        doReset();

        // Single CPU read.
        applyStimulus(0, 0, 0, 12'h000, 8'h00, 1, 0, 12'h200, 8'h00, 0, 12'h000);
        checkOutput("rd_gnts",     32'({bus.ldr_gnt, bus.cpu_gnt, bus.drw_gnt}), 3'b010);
        checkOutput("rd_mem_en",   32'({bus.mem_en, bus.mem_write}), 2'b10);
        checkOutput("rd_mem_addr", 32'(bus.mem_addr), 32'h200);
        idleCycle();
        checkOutput("rd_rvalids",  32'({bus.ldr_rvalid, bus.cpu_rvalid, bus.drw_rvalid}), 3'b010);
        checkOutput("rd_rdata",    32'(bus.rdata), 32'hAB);

        // CPU/draw round-robin after a fresh reset: CPU first, then alternate.
        doReset();
        prev_cpu = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 12'h000, 8'h00, 1, 0, 12'h200, 8'h00, 1, 12'h201);
            exp_cpu = (i % 2 == 0);
            checkOutput($sformatf("rr_cpu_gnt%0d", i), 32'(bus.cpu_gnt), 32'(exp_cpu));
            checkOutput($sformatf("rr_drw_gnt%0d", i), 32'(bus.drw_gnt), 32'(!exp_cpu));
            if (i == 0) begin
                checkOutput("rr_rvalid0", 32'({bus.cpu_rvalid, bus.drw_rvalid}), 0);
            end else begin
                checkOutput($sformatf("rr_rvalid%0d", i), 32'({bus.cpu_rvalid, bus.drw_rvalid}),
                            prev_cpu ? 2'b10 : 2'b01);
                checkOutput($sformatf("rr_rdata%0d", i), 32'(bus.rdata), prev_cpu ? 32'hAB : 32'hCD);
            end
            prev_cpu = exp_cpu;
        end
        idleCycle();
        checkOutput("rr_last_rvalid", 32'({bus.cpu_rvalid, bus.drw_rvalid}), 2'b01);
        checkOutput("rr_last_rdata",  32'(bus.rdata), 32'hCD);

        // Locked loader burst with the CPU waiting, including a gap cycle.
        applyStimulus(1, 1, 1, 12'h300, 8'hA0, 1, 0, 12'h200, 8'h00, 0, 12'h000);
        checkOutput("lk_gnts0", 32'({bus.ldr_gnt, bus.cpu_gnt}), 2'b10);
        applyStimulus(1, 1, 1, 12'h301, 8'hA1, 1, 0, 12'h200, 8'h00, 0, 12'h000);
        checkOutput("lk_gnts1", 32'({bus.ldr_gnt, bus.cpu_gnt}), 2'b10);
        applyStimulus(0, 1, 0, 12'h000, 8'h00, 1, 0, 12'h200, 8'h00, 0, 12'h000);
        checkOutput("lk_gap_gnts", 32'({bus.ldr_gnt, bus.cpu_gnt, bus.mem_en}), 0);
        applyStimulus(1, 1, 1, 12'h302, 8'hA2, 1, 0, 12'h200, 8'h00, 0, 12'h000);
        checkOutput("lk_gnts2", 32'({bus.ldr_gnt, bus.cpu_gnt}), 2'b10);
        applyStimulus(1, 1, 1, 12'h303, 8'hA3, 1, 0, 12'h200, 8'h00, 0, 12'h000);
        checkOutput("lk_gnts3", 32'({bus.ldr_gnt, bus.cpu_gnt}), 2'b10);
        applyStimulus(0, 0, 0, 12'h000, 8'h00, 1, 0, 12'h200, 8'h00, 0, 12'h000);
        checkOutput("lk_release_cpu", 32'(bus.cpu_gnt), 1);
        for (int k = 0; k < 5; k++) begin
            if (k < 4) applyStimulus(1, 0, 0, 12'h300 + 12'(k), 8'h00, 0, 0, 12'h000, 8'h00, 0, 12'h000);
            else       idleCycle();
            if (k == 0) begin
                checkOutput("lk_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
                checkOutput("lk_cpu_rdata",  32'(bus.rdata), 32'hAB);
            end else begin
                checkOutput($sformatf("lk_rb_rvalid%0d", k), 32'(bus.ldr_rvalid), 1);
                checkOutput($sformatf("lk_rb_rdata%0d", k),  32'(bus.rdata), 32'hA0 + k - 1);
            end
        end

        // Write protect: loader to 0x1FF, then CPU to 0x100.
        saved_1ff = ram[12'h1FF];
        saved_100 = ram[12'h100];
        applyStimulus(1, 0, 1, 12'h1FF, 8'h55, 0, 0, 12'h000, 8'h00, 0, 12'h000);
        checkOutput("wp_ldr_gnt", 32'(bus.ldr_gnt), 1);
        checkOutput("wp_ldr_mem", 32'({bus.mem_en, bus.mem_write}), 0);
        applyStimulus(0, 0, 0, 12'h000, 8'h00, 1, 1, 12'h100, 8'h66, 0, 12'h000);
        checkOutput("wp_cpu_gnt", 32'(bus.cpu_gnt), 1);
        checkOutput("wp_cpu_mem", 32'({bus.mem_en, bus.mem_write}), 0);
        checkOutput("wp_1ff_kept", 32'(ram[12'h1FF]), 32'(saved_1ff));
        checkOutput("wp_no_rvalid", 32'(bus.ldr_rvalid), 0);
`ifdef ARB_WPROT_ERR_EN
        checkOutput("wp_err_set",  32'(wp_err), 1);
        checkOutput("wp_addr_1ff", 32'(wp_addr), 32'h1FF);
`endif
        applyStimulus(1, 0, 1, 12'h010, 8'h77, 0, 0, 12'h000, 8'h00, 0, 12'h000);
`ifdef ARB_WPROT_ERR_EN
        checkOutput("wp_addr_first", 32'(wp_addr), 32'h1FF);
        wp_clr = 1'b1;
`endif
        idleCycle();
        checkOutput("wp_100_kept", 32'(ram[12'h100]), 32'(saved_100));
`ifdef ARB_WPROT_ERR_EN
        checkOutput("wp_clr_set_err",  32'(wp_err), 1);
        checkOutput("wp_clr_set_addr", 32'(wp_addr), 32'h010);
`endif
        idleCycle();
`ifdef ARB_WPROT_ERR_EN
        wp_clr = 1'b0;
        idleCycle();
        checkOutput("wp_cleared", 32'({wp_err, wp_addr}), 0);
`endif

        // Reset in the middle of a locked burst with a read in flight.
        applyStimulus(1, 1, 1, 12'h304, 8'hB4, 0, 0, 12'h000, 8'h00, 0, 12'h000);
        checkOutput("mr_lock_gnt", 32'(bus.ldr_gnt), 1);
        applyStimulus(1, 1, 0, 12'h300, 8'h00, 0, 0, 12'h000, 8'h00, 0, 12'h000);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mr_gnts",   32'({bus.ldr_gnt, bus.cpu_gnt, bus.drw_gnt}), 0);
        checkOutput("mr_mem",    32'({bus.mem_en, bus.mem_write}), 0);
        checkOutput("mr_rvalid", 32'({bus.ldr_rvalid, bus.cpu_rvalid, bus.drw_rvalid}), 0);
        checkOutput("mr_rdata",  32'(bus.rdata), 0);
        @(negedge clk);
        bus.ldr_req = 1'b0;
        reset_n     = 1'b1;
        #1;
        checkOutput("mr_post_rvalid", 32'(bus.ldr_rvalid), 0);
        applyStimulus(0, 1, 0, 12'h000, 8'h00, 1, 0, 12'h200, 8'h00, 1, 12'h201);
        checkOutput("mr_tie_gnts", 32'({bus.cpu_gnt, bus.drw_gnt}), 2'b10);
        idleCycle();
        checkOutput("mr_tie_rvalid", 32'({bus.ldr_rvalid, bus.cpu_rvalid}), 2'b01);

        // Top-of-memory write then read-after-write from the draw unit.
        applyStimulus(0, 0, 0, 12'h000, 8'h00, 1, 1, 12'hFFF, 8'h5A, 0, 12'h000);
        checkOutput("top_cpu_gnt",  32'(bus.cpu_gnt), 1);
        checkOutput("top_wr_mem",   32'({bus.mem_en, bus.mem_write}), 3);
        checkOutput("top_wr_addr",  32'(bus.mem_addr), 32'hFFF);
        applyStimulus(0, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 1, 12'hFFF);
        checkOutput("top_drw_gnt",  32'(bus.drw_gnt), 1);
        checkOutput("top_no_wr_rv", 32'(bus.cpu_rvalid), 0);
        idleCycle();
        checkOutput("top_drw_rvalid", 32'(bus.drw_rvalid), 1);
        checkOutput("top_drw_rdata",  32'(bus.rdata), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Shares the single read/write port (port A) of the CPU dual-port memory among three requesters: the ROM loader, the CPU core, and the sprite draw unit (DRW row fetches). It sits between those requesters and the memory's a_en/a_write/a_addr/a_in/a_out pins. It does one access per clock and routes read data back to the owner of the access. It also enforces the 0x000–0x1FF write-protect region at the arbiter, not only inside the memory.

Parameters:
ADDR_W, 12, address width (4 KiB space)
DATA_W, 8, data width
PROT_LIMIT, 512, writes with addr < PROT_LIMIT are suppressed

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
ldr_req  in  1  loader access request
ldr_lock  in  1  loader requests exclusive ownership (burst upload)
ldr_write  in  1  1=write, 0=read
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_gnt  out  1  loader access issued this cycle
ldr_rvalid  out  1  loader read data valid
cpu_req / cpu_write / cpu_addr / cpu_wdata  in  1/1/ADDR_W/DATA_W  CPU request bundle
cpu_gnt  out  1  CPU access issued this cycle
cpu_rvalid  out  1  CPU read data valid
drw_req  in  1  draw unit read request (read-only)
drw_addr  in  ADDR_W  draw read address
drw_gnt  out  1  draw access issued this cycle
drw_rvalid  out  1  draw read data valid
rdata  out  DATA_W  shared read data bus (qualify with *_rvalid)
mem_en  out  1  to memory a_en
mem_write  out  1  to memory a_write
mem_addr  out  ADDR_W  to memory a_addr
mem_wdata  out  DATA_W  to memory a_in
mem_rdata  in  DATA_W  from memory a_out (registered, 1-cycle latency)

Behaviour:
- Reset (async, reset_n low): state=ARB; all *_gnt, *_rvalid, mem_en, mem_write = 0; mem_addr, mem_wdata = 0; rr_last = DRW, so the CPU wins the first CPU/draw tie; resp_owner = NONE. A reset while LOCKED returns to ARB. Any in-flight rvalid is dropped.
- Handshake: a requester holds req, write, addr and wdata stable until it sees gnt. gnt is combinational from the state and the req inputs and lasts exactly one cycle per access. The requester may keep req high for back-to-back accesses; each cycle with gnt is one access.
- mem_* are driven combinationally from the winning request in its gnt cycle. When there is no grant, mem_en=0 and mem_write=0.
- Read latency: for a read granted in cycle N, the matching *_rvalid is registered high in cycle N+1 and rdata=mem_rdata in that cycle. Writes never produce rvalid. Throughput is 1 access per cycle with no bubbles.
- State ARB:
  - Priority: the loader beats CPU and draw.
  - If ldr_req and ldr_lock are both high at a loader grant, go to LOCKED.
  - CPU vs draw is round-robin. On a tie, grant the one not equal to rr_last. rr_last updates only on CPU or draw grants.
  - Starvation bound: while ldr_req stays low, a waiting CPU or draw request is granted within 2 cycles.
- State LOCKED:
  - Only the loader can be granted; cpu_gnt and drw_gnt are held 0.
  - When ldr_lock falls, go to ARB on the next edge. In the cycle ldr_lock is low, arbitration is already normal (combinational on ldr_lock).
- Write protect: a write with addr < PROT_LIMIT is still granted, so the requester never hangs, but mem_en=0 that cycle and memory is untouched.
- Addresses are full ADDR_W with no wrap logic; 0xFFF is a legal address.

Optional Feature:
ARB_WPROT_ERR_EN
- Defined: adds ports wp_err (out, 1), wp_addr (out, ADDR_W) and wp_clr (in, 1).
  - A suppressed protected write sets wp_err (sticky) and captures its address in wp_addr, first violation only.
  - wp_clr clears both. If wp_clr and a new violation occur in the same cycle, the set wins and wp_addr takes the new address.
  - Both reset to 0.
- Undefined: no such ports; protected writes are silently dropped.

Decomposition:
- Package cpu_mem_pkg holds:
  - ADDR_W, DATA_W, PROT_LIMIT (0x200);
  - the owner enum {NONE, LDR, CPU, DRW} used for resp_owner and rr_last;
  - the state enum {ARB, LOCKED}.
- One sub-module is natural: rr_arb2, a two-way round-robin picker with a last-winner register. It is instantiated for CPU/draw, and the loader priority and lock wrap around it.

Test Plan:
- Reset, then cpu_req read 0x200 with memory preloaded 0xAB → cpu_gnt in cycle 1, cpu_rvalid plus rdata=0xAB in cycle 2, all other gnt/rvalid 0.
- cpu_req and drw_req held high for 6 cycles (reads) → grants alternate CPU, DRW, CPU…; the CPU wins first after reset; each rvalid follows its own gnt by one cycle.
- ldr_req+ldr_lock with 4 writes 0x300..0x303 while cpu_req is high → cpu_gnt=0 throughout LOCKED; the CPU is granted the cycle ldr_lock drops; readback gives the written bytes.
- Loader write 0x1FF data 0x55 → ldr_gnt=1, mem_en=0, location unchanged. With ARB_WPROT_ERR_EN: wp_err=1, wp_addr=0x1FF; wp_clr together with a write to 0x010 leaves wp_err=1 and wp_addr=0x010.
- Assert reset_n=0 mid-LOCKED with a read in flight → all outputs 0 immediately, no rvalid after release, state ARB, and the CPU wins the next CPU/draw tie.
- A CPU write to 0xFFF and a draw read from 0xFFF granted in consecutive cycles → the draw rdata equals the written value.
